// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: widths, funct3 codes,
// FSM encoding, request payload and alignment/legality helpers.
package mem_pkg;
   localparam int XLEN = 32;
   localparam int AW   = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b10;
   localparam logic [1:0] RW_WRITE = 2'b01;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_RESP} mau_state_e;

   typedef struct packed {
      logic            is_store;
      logic [2:0]      funct3;
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] wdata;
   } mem_req_t;

   function automatic logic f3_valid(input logic is_store, input logic [2:0] f3);
      if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
   endfunction
endpackage

// File: rtl/mem_req_fifo.sv
// Request FIFO with a kill bit per entry; flush marks every queued load,
// including one pushed in the same cycle, so it can be dropped at the head.
module mem_req_fifo import mem_pkg::*; #(
   parameter int TAG_W = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  mem_req_t         push_req,
   input  logic [TAG_W-1:0] push_tag,
   input  logic             pop,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output mem_req_t         head_req,
   output logic [TAG_W-1:0] head_tag,
   output logic             head_kill
);
   localparam int PW = $clog2(DEPTH);

   mem_req_t         req_q [DEPTH];
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [DEPTH-1:0] kill_q;
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [PW:0]      count;

   assign full      = (count == (PW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign head_req  = req_q[rd_ptr];
   assign head_tag  = tag_q[rd_ptr];
   assign head_kill = kill_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         req_q[wr_ptr] <= push_req;
         tag_q[wr_ptr] <= push_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         kill_q <= '0;
      end else begin
         // stale slots may get marked too; a later push rewrites their kill bit
         if (flush)
            for (int i = 0; i < DEPTH; i++)
               if (!req_q[i].is_store) kill_q[i] <= 1'b1;
         if (push) begin
            kill_q[wr_ptr] <= flush && !push_req.is_store;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: queues requests, issues one memory command at a time,
// formats byte lanes and returns a tagged completion.
module mem_access_unit import mem_pkg::*; #(
   parameter int TAG_W = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_is_store,
   input  logic [2:0]       req_funct3,
   input  logic [AW-1:0]    req_addr,
   input  logic [XLEN-1:0]  req_wdata,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   input  logic             mem_free,
   input  logic             mem_read_valid,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic [1:0]       mem_rw_flag,
   output logic [AW-1:0]    mem_addr,
   output logic [XLEN-1:0]  mem_wdata,
   output logic [3:0]       mem_mask,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [TAG_W-1:0] res_tag,
   output logic [XLEN-1:0]  res_data,
   output logic             res_is_store,
   output logic             res_err
);
   mau_state_e       state;
   mem_req_t         push_req, head;
   logic [TAG_W-1:0] head_tag;
   logic             full, empty, head_kill, push, pop;
   logic             kill_now, bad_now, resp_load;
   logic [3:0]       fmt_mask;
   logic [XLEN-1:0]  fmt_wdata, fmt_rdata, rd_shift;

   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign push_req  = '{is_store: req_is_store, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
   assign kill_now  = head_kill || (flush && !head.is_store);
   assign bad_now   = misaligned(head.funct3, head.addr[1:0]) || !f3_valid(head.is_store, head.funct3);
   assign pop       = !empty && (((state == ST_IDLE) && (kill_now || bad_now)) ||
                                 ((state == ST_BUSY) && mem_free));

   mem_req_fifo #(.TAG_W(TAG_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .push(push), .push_req(push_req), .push_tag(req_tag),
      .pop(pop), .flush(flush),
      .full(full), .empty(empty),
      .head_req(head), .head_tag(head_tag), .head_kill(head_kill)
   );

   always_comb begin
      fmt_mask  = 4'b1111;
      fmt_wdata = head.wdata;
      case (head.funct3[1:0])
         2'b00: begin
            fmt_mask  = 4'b0001 << head.addr[1:0];
            fmt_wdata = {4{head.wdata[7:0]}};
         end
         2'b01: begin
            fmt_mask  = 4'b0011 << head.addr[1:0];
            fmt_wdata = {2{head.wdata[15:0]}};
         end
         default: ;
      endcase
      rd_shift = mem_rdata >> {head.addr[1:0], 3'b000};
      case (head.funct3)
         F3_B:    fmt_rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
         F3_H:    fmt_rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
         F3_BU:   fmt_rdata = {24'b0, rd_shift[7:0]};
         F3_HU:   fmt_rdata = {16'b0, rd_shift[15:0]};
         default: fmt_rdata = rd_shift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         mem_rw_flag  <= RW_NONE;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_mask     <= '0;
         res_valid    <= 1'b0;
         res_tag      <= '0;
         res_data     <= '0;
         res_is_store <= 1'b0;
         res_err      <= 1'b0;
         resp_load    <= 1'b0;
      end else begin
         mem_rw_flag <= RW_NONE;
         case (state)
            ST_IDLE: if (!empty && !kill_now) begin
               if (bad_now) begin
                  state        <= ST_RESP;
                  res_valid    <= 1'b1;
                  res_err      <= 1'b1;
                  res_data     <= '0;
                  res_tag      <= head_tag;
                  res_is_store <= head.is_store;
                  resp_load    <= !head.is_store;
               end else if (mem_free) begin
                  state       <= ST_ISSUE;
                  mem_rw_flag <= head.is_store ? RW_WRITE : RW_READ;
                  mem_addr    <= head.addr;
                  mem_wdata   <= fmt_wdata;
                  mem_mask    <= fmt_mask;
               end
            end
            ST_ISSUE: state <= ST_BUSY;
            // a killed head still waits for the memory, then vanishes silently
            ST_BUSY: if (mem_free) begin
               if (kill_now) begin
                  state <= ST_IDLE;
               end else begin
                  state        <= ST_RESP;
                  res_valid    <= 1'b1;
                  res_err      <= 1'b0;
                  res_tag      <= head_tag;
                  res_is_store <= head.is_store;
                  resp_load    <= !head.is_store;
                  res_data     <= (!head.is_store && mem_read_valid) ? fmt_rdata : '0;
               end
            end
            ST_RESP: if (res_ready || (flush && resp_load)) begin
               state        <= ST_IDLE;
               res_valid    <= 1'b0;
               res_err      <= 1'b0;
               res_is_store <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a small memory that drops
// mem_free for two cycles per command.
module tb_mem_access_unit;
   import mem_pkg::*;
   localparam int TAG_W = 4;

   logic             clk = 1'b0, rst = 1'b1;
   logic             req_valid = 1'b0, req_ready, req_is_store = 1'b0;
   logic [2:0]       req_funct3 = '0;
   logic [31:0]      req_addr = '0, req_wdata = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             flush = 1'b0;
   logic             mem_free, mem_read_valid;
   logic [31:0]      mem_rdata;
   logic [1:0]       mem_rw_flag;
   logic [31:0]      mem_addr, mem_wdata;
   logic [3:0]       mem_mask;
   logic             res_valid, res_ready = 1'b0, res_is_store, res_err;
   logic [TAG_W-1:0] res_tag;
   logic [31:0]      res_data;

   int checks = 0, errors = 0;
   int pulses = 0, resp_cnt = 0, resp_ld = 0;
   logic [3:0]       last_mask;
   logic [31:0]      last_wdata;
   logic [TAG_W-1:0] last_tag;

   always #5 clk = ~clk;

   mem_access_unit #(.TAG_W(TAG_W), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
      .flush(flush),
      .mem_free(mem_free), .mem_read_valid(mem_read_valid), .mem_rdata(mem_rdata),
      .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
      .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data),
      .res_is_store(res_is_store), .res_err(res_err)
   );

   logic [31:0] mem [16];
   int          mcnt;
   logic        op_rd;
   logic [31:0] op_addr, op_wdata;
   logic [3:0]  op_mask;

   always @(posedge clk) begin
      if (rst) begin
         mcnt <= 0; mem_free <= 1'b1; mem_read_valid <= 1'b0; mem_rdata <= '0;
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         mem[2] <= 32'h1122_3344;
      end else begin
         mem_read_valid <= 1'b0;
         if (mem_rw_flag != 2'b00) begin
            mcnt <= 2; mem_free <= 1'b0; op_rd <= mem_rw_flag[1];
            op_addr <= mem_addr; op_wdata <= mem_wdata; op_mask <= mem_mask;
         end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
               mem_free <= 1'b1;
               if (op_rd) begin
                  mem_read_valid <= 1'b1;
                  mem_rdata <= mem[op_addr[5:2]];
               end else begin
                  for (int b = 0; b < 4; b++)
                     if (op_mask[b]) mem[op_addr[5:2]][8*b +: 8] <= op_wdata[8*b +: 8];
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      if (mem_rw_flag != 2'b00) begin
         pulses <= pulses + 1; last_mask <= mem_mask; last_wdata <= mem_wdata;
      end
      if (res_valid && res_ready) begin
         resp_cnt <= resp_cnt + 1; last_tag <= res_tag;
         if (!res_is_store) resp_ld <= resp_ld + 1;
      end
   end

   task automatic tick(input int k);
      repeat (k) begin @(posedge clk); #1; end
   endtask

   task automatic push(input logic st, input logic [2:0] f3, input logic [31:0] a, d,
                       input logic [TAG_W-1:0] t);
      int n = 0;
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = d; req_tag = t;
      while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) begin
         checks++; errors++; $display("FAIL push_timeout: req_ready=%0b required 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (!res_valid && n < 60) begin @(posedge clk); #1; n++; end
   endtask

   task automatic consume;
      res_ready = 1'b1; tick(1); res_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; tick(3); rst = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
      checks++; if (res_valid !== 1'b0 || res_err !== 1'b0 || res_is_store !== 1'b0) begin
         errors++; $display("FAIL reset_res_flags: got %0b%0b%0b want 000", res_valid, res_err, res_is_store); end
      checks++; if (mem_rw_flag !== 2'b00) begin errors++; $display("FAIL reset_rw_flag: got %b want 00", mem_rw_flag); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_mask !== 4'h0) begin
         errors++; $display("FAIL reset_mem_cmd: got %h %h %b want zeros", mem_addr, mem_wdata, mem_mask); end
      checks++; if (res_data !== 32'h0 || res_tag !== '0) begin
         errors++; $display("FAIL reset_res_payload: got %h %h want 0 0", res_data, res_tag); end
   endtask

   task automatic test_lw_latency;
      int n;
      push(1'b0, F3_W, 32'h8, 32'h0, 4'd3);
      wait_resp(n);
      checks++; if (n != 5) begin errors++; $display("FAIL lw_latency: got %0d want 5", n); end
      checks++; if (res_data !== 32'h1122_3344) begin errors++; $display("FAIL lw_data: got %h want 11223344", res_data); end
      checks++; if (res_tag !== 4'd3 || res_err !== 1'b0) begin
         errors++; $display("FAIL lw_tag_err: got tag %0d err %0b want 3 0", res_tag, res_err); end
      consume;
   endtask

   task automatic test_byte_lanes;
      int n;
      push(1'b1, F3_B, 32'h5, 32'h0000_00AB, 4'd1);
      wait_resp(n);
      checks++; if (last_mask !== 4'b0010) begin errors++; $display("FAIL sb_mask: got %b want 0010", last_mask); end
      checks++; if (last_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want ababab ab", last_wdata); end
      checks++; if (res_valid !== 1'b1 || res_is_store !== 1'b1 || res_data !== 32'h0) begin
         errors++; $display("FAIL sb_resp: got v%0b s%0b %h want v1 s1 0", res_valid, res_is_store, res_data); end
      consume;
      push(1'b0, F3_B, 32'h5, 32'h0, 4'd2); wait_resp(n);
      checks++; if (res_data !== 32'hFFFF_FFAB) begin errors++; $display("FAIL lb_data: got %h want ffffffab", res_data); end
      consume;
      push(1'b0, F3_BU, 32'h5, 32'h0, 4'd2); wait_resp(n);
      checks++; if (res_data !== 32'h0000_00AB) begin errors++; $display("FAIL lbu_data: got %h want 000000ab", res_data); end
      consume;
      push(1'b0, F3_H, 32'h4, 32'h0, 4'd2); wait_resp(n);
      checks++; if (res_data !== 32'hFFFF_AB00) begin errors++; $display("FAIL lh_data: got %h want ffffab00", res_data); end
      consume;
   endtask

   task automatic test_misaligned;
      int n, p0;
      p0 = pulses;
      push(1'b0, F3_H, 32'h3, 32'h0, 4'd5);
      wait_resp(n);
      checks++; if (n != 1 || res_err !== 1'b1 || res_data !== 32'h0) begin
         errors++; $display("FAIL lh_misaligned: got lat %0d err %0b data %h want 1 1 0", n, res_err, res_data); end
      consume;
      checks++; if (pulses != p0) begin errors++; $display("FAIL misaligned_no_access: got %0d pulses want 0", pulses - p0); end
   endtask

   task automatic test_full;
      int p0, r0, n;
      p0 = pulses;
      for (int i = 0; i < 4; i++) push(1'b0, F3_W, 32'h8, 32'h0, 4'(8 + i));
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", req_ready); end
      tick(15);
      checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL full_one_pulse: got %0d want 1", pulses - p0); end
      checks++; if (res_valid !== 1'b1 || res_tag !== 4'd8) begin
         errors++; $display("FAIL full_hold: got v%0b tag %0d want v1 tag 8", res_valid, res_tag); end
      r0 = resp_cnt; n = 0; res_ready = 1'b1;
      while (resp_cnt - r0 < 4 && n < 100) begin tick(1); n++; end
      res_ready = 1'b0; tick(2);
      checks++; if (resp_cnt - r0 != 4 || pulses - p0 != 4) begin
         errors++; $display("FAIL full_drain: got %0d resp %0d pulses want 4 4", resp_cnt - r0, pulses - p0); end
   endtask

   task automatic test_flush_busy;
      int r0, l0;
      r0 = resp_cnt; l0 = resp_ld; res_ready = 1'b1;
      push(1'b0, F3_W, 32'h8, 32'h0, 4'd1);
      push(1'b1, F3_W, 32'hC, 32'hCAFE_F00D, 4'd2);
      push(1'b0, F3_W, 32'h8, 32'h0, 4'd3);
      flush = 1'b1; tick(1); flush = 1'b0;
      tick(30); res_ready = 1'b0;
      checks++; if (resp_ld != l0) begin errors++; $display("FAIL flush_no_load_resp: got %0d want 0", resp_ld - l0); end
      checks++; if (resp_cnt - r0 != 1 || last_tag !== 4'd2) begin
         errors++; $display("FAIL flush_store_resp: got %0d resp tag %0d want 1 tag 2", resp_cnt - r0, last_tag); end
      checks++; if (mem[3] !== 32'hCAFE_F00D) begin errors++; $display("FAIL flush_store_write: got %h want cafef00d", mem[3]); end
   endtask

   task automatic test_flush_resp;
      int n;
      push(1'b0, F3_W, 32'h8, 32'h0, 4'd6);
      wait_resp(n);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL flush_resp_pre: got %0b want 1", res_valid); end
      flush = 1'b1; tick(1); flush = 1'b0;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_resp_drop: got %0b want 0", res_valid); end
      tick(2);
   endtask

   task automatic test_rst_busy;
      int n;
      push(1'b0, F3_W, 32'h8, 32'h0, 4'd7);
      tick(2);
      rst = 1'b1; tick(1);
      checks++; if (res_valid !== 1'b0 || mem_rw_flag !== 2'b00 || req_ready !== 1'b1) begin
         errors++; $display("FAIL rst_busy: got v%0b rw%b rdy%0b want v0 rw00 rdy1", res_valid, mem_rw_flag, req_ready); end
      rst = 1'b0; tick(10);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_no_resp: got %0b want 0", res_valid); end
      push(1'b0, F3_W, 32'h8, 32'h0, 4'd4);
      wait_resp(n);
      checks++; if (n != 5 || res_data !== 32'h1122_3344 || res_tag !== 4'd4) begin
         errors++; $display("FAIL post_rst_lw: got lat %0d %h tag %0d want 5 11223344 4", n, res_data, res_tag); end
      consume;
   endtask

   initial begin
      test_reset;
      test_lw_latency;
      test_byte_lanes;
      test_misaligned;
      test_full;
      test_flush_busy;
      test_flush_resp;
      test_rst_busy;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
